// File: rtl/im_loader.sv
// Instruction-memory loader: turns a host byte stream (16-bit word count, then
// big-endian 32-bit words) into IM writes. Define LOADER_CSUM_EN for a trailing XOR checksum byte.
module im_loader #(
  parameter logic [15:0] START_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst_f,
  output logic        done,
  output logic        err,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
`ifdef LOADER_CSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

`ifdef LOADER_CSUM_EN
  localparam state_t END_STATE = S_CSUM;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;
  logic [15:0] r_im_addr;
  logic [31:0] r_im_wdata;
  logic        w_xfer;
  logic        w_err;
  logic [31:0] w_next_asm;
  logic [15:0] w_len;

  // Handshake: a byte moves only on a rising edge where byte_valid && byte_ready;
  // byte_ready is a pure decode of the state register, so it never depends on byte_valid.
  assign byte_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA)
`ifdef LOADER_CSUM_EN
                      || (r_state == S_CSUM)
`endif
                      ;
  assign w_xfer     = byte_valid && byte_ready;
  assign w_next_asm = {r_asm, byte_data};
  assign w_len      = {r_count[15:8], byte_data};

`ifdef LOADER_CSUM_EN
  logic [7:0] r_csum;
  logic       r_err;
  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= 16'h0000;
      r_word_idx <= 16'h0000;
      r_byte_cnt <= 2'd0;
      r_asm      <= 24'h000000;
      r_im_addr  <= 16'h0000;
      r_im_wdata <= 32'h0000_0000;
`ifdef LOADER_CSUM_EN
      r_csum     <= 8'h00;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_LEN_HI;
            r_count    <= 16'h0000;
            r_word_idx <= 16'h0000;
            r_byte_cnt <= 2'd0;
            r_asm      <= 24'h000000;
`ifdef LOADER_CSUM_EN
            r_csum     <= 8'h00;
            r_err      <= 1'b0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_count[15:8] <= byte_data;
            r_state       <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= byte_data;
            r_state      <= (w_len == 16'h0000) ? END_STATE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_asm      <= w_next_asm[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CSUM_EN
            r_csum     <= r_csum ^ byte_data;
`endif
            // Address and data are latched here so they are valid for the whole WRITE cycle.
            if (r_byte_cnt == 2'd3) begin
              r_state    <= S_WRITE;
              r_im_addr  <= START_ADDR + r_word_idx;
              r_im_wdata <= w_next_asm;
            end
          end
        end
        S_WRITE: begin
          r_word_idx <= r_word_idx + 16'd1;
          r_state    <= ((r_word_idx + 16'd1) == r_count) ? END_STATE : S_DATA;
        end
`ifdef LOADER_CSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            r_err   <= (byte_data != r_csum);
            r_state <= S_DONE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign im_we       = (r_state == S_WRITE);
  assign im_addr     = r_im_addr;
  assign im_wdata    = r_im_wdata;
  assign done        = (r_state == S_DONE) && !w_err;
  assign cpu_rst_f   = done;
  assign err         = w_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: two instances (START_ADDR 0000 and FFFF) share one random
// byte stream; expected writes come from a word-list model of the stream format.
module tb_im_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready_a, im_we_a, cpu_rst_f_a, done_a, err_a;
  logic        byte_ready_b, im_we_b, cpu_rst_f_b, done_b, err_b;
  logic [15:0] im_addr_a, im_addr_b;
  logic [31:0] im_wdata_a, im_wdata_b;
  logic [2:0]  dbg_a, dbg_b;

`ifdef LOADER_CSUM_EN
  localparam bit CSUM_BUILD = 1'b1;
`else
  localparam bit CSUM_BUILD = 1'b0;
`endif

  im_loader u_dut_a (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready_a), .im_we(im_we_a), .im_addr(im_addr_a), .im_wdata(im_wdata_a),
    .cpu_rst_f(cpu_rst_f_a), .done(done_a), .err(err_a), .o_dbg_state(dbg_a)
  );

  im_loader #(.START_ADDR(16'hFFFF)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready_b), .im_we(im_we_b), .im_addr(im_addr_b), .im_wdata(im_wdata_b),
    .cpu_rst_f(cpu_rst_f_b), .done(done_b), .err(err_b), .o_dbg_state(dbg_b)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit noisy_start = 1'b0;

  logic [47:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  logic [31:0] load_words[$];

  // Write monitors: one entry per cycle of im_we, so a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (im_we_a === 1'b1) got_a.push_back({im_addr_a, im_wdata_a});
    if (im_we_b === 1'b1) got_b.push_back({im_addr_b, im_wdata_b});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    int waits;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      start      = noisy_start && ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    waits = 0;
    while (!(byte_ready_a === 1'b1 && byte_ready_b === 1'b1) && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("byte_ready_wait", 64'({byte_ready_a, byte_ready_b}), 64'(2'b11));
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  // Called in the cycle right after a word's 4th byte: a fresh byte must be refused there.
  task automatic probe_write();
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    @(negedge clk);
    check("ready_in_write", 64'({byte_ready_a, byte_ready_b}), 64'(2'b00));
    check("we_in_write", 64'({im_we_a, im_we_b}), 64'(2'b11));
    byte_valid = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_start_cpu_rst_f", 64'({cpu_rst_f_a, cpu_rst_f_b}), 64'(2'b00));
    check("load_start_done_err", 64'({done_a, done_b, err_a, err_b}), 64'(4'b0000));
  endtask

  task automatic do_load(input bit csum_good);
    logic [7:0]  x;
    logic [15:0] n;
    logic [31:0] w;
    bit          exp_ok;
    int          waits;
    n = 16'(load_words.size());
    x = 8'h00;
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
    for (int i = 0; i < load_words.size(); i++) begin
      w = load_words[i];
      exp_a.push_back({16'(i), w});
      exp_b.push_back({16'(32'hFFFF + i), w});
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    exp_ok = csum_good || !CSUM_BUILD;

    start_load();
    drive_byte(n[15:8]);
    drive_byte(n[7:0]);
    for (int i = 0; i < load_words.size(); i++) begin
      w = load_words[i];
      for (int k = 3; k >= 0; k--) drive_byte(w[8*k +: 8]);
      probe_write();
    end
    if (CSUM_BUILD) drive_byte(csum_good ? x : (x ^ 8'h01));
    start = 1'b0;

    waits = 0;
    while (!(done_a === 1'b1 || err_a === 1'b1) && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check("end_done", 64'({done_a, done_b}), 64'({exp_ok, exp_ok}));
    check("end_cpu_rst_f", 64'({cpu_rst_f_a, cpu_rst_f_b}), 64'({exp_ok, exp_ok}));
    check("end_err", 64'({err_a, err_b}), 64'({!exp_ok, !exp_ok}));
    check("write_count_a", 64'(got_a.size()), 64'(exp_a.size()));
    check("write_count_b", 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check("write_a", 64'(got_a[i]), 64'(exp_a[i]));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check("write_b", 64'(got_b[i]), 64'(exp_b[i]));
    if (exp_a.size() > 0) begin
      check("hold_a", 64'({im_addr_a, im_wdata_a}), 64'(exp_a[exp_a.size()-1]));
      check("hold_b", 64'({im_addr_b, im_wdata_b}), 64'(exp_b[exp_b.size()-1]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_a", 64'({byte_ready_a, im_we_a, im_addr_a, im_wdata_a, cpu_rst_f_a, done_a, err_a}), 64'(0));
    check("reset_b", 64'({byte_ready_b, im_we_b, im_addr_b, im_wdata_b, cpu_rst_f_b, done_b, err_b}), 64'(0));
    rst = 1'b0;
    byte_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ignores_bytes", 64'({byte_ready_a, byte_ready_b, cpu_rst_f_a, done_a}), 64'(0));
    byte_valid = 1'b0;

    // Two-word directed load; instance B wraps FFFF -> 0000.
    load_words = '{32'hDEADBEEF, 32'h12345678};
    do_load(1'b1);

    // Empty program.
    load_words.delete();
    do_load(1'b1);

    // Random programs with random gaps and stray start pulses during the load.
    noisy_start = 1'b1;
    for (int t = 0; t < 4; t++) begin
      load_words.delete();
      repeat ($urandom_range(1, 5)) load_words.push_back($urandom);
      do_load(1'b1);
    end
    noisy_start = 1'b0;

    // Reset after two data bytes of a word: nothing written, processor stays in reset.
    got_a.delete(); got_b.delete();
    start_load();
    drive_byte(8'h00);
    drive_byte(8'h01);
    drive_byte(8'hAA);
    drive_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midload_reset_a", 64'({byte_ready_a, im_we_a, im_addr_a, im_wdata_a, cpu_rst_f_a, done_a}), 64'(0));
    check("midload_reset_b", 64'({byte_ready_b, im_we_b, im_addr_b, im_wdata_b, cpu_rst_f_b, done_b}), 64'(0));
    byte_valid = 1'b1;
    byte_data  = 8'hCC;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    check("midload_no_write", 64'({16'(got_a.size()), 16'(got_b.size())}), 64'(0));
    check("midload_idle", 64'({byte_ready_a, cpu_rst_f_a, byte_ready_b, cpu_rst_f_b}), 64'(0));
    load_words.delete();
    repeat (3) load_words.push_back($urandom);
    do_load(1'b1);

    // Checksum pair: DEADBEEF XORs to 22; the second load sends 23.
    load_words = '{32'hDEADBEEF};
    do_load(1'b1);
    do_load(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
